// File: rtl/locked_adder_key_loader.sv
// Serial key loader and operand/result wrapper around an external logic-locked adder.
// The key becomes visible to the adder only after all KEY_W bits have been shifted in.
module locked_adder_key_loader #(
  parameter int DATA_W = 16,
  parameter int KEY_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              key_start_i,
  input  logic              key_bit_valid_i,
  input  logic              key_bit_i,
  output logic              key_loaded_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] add1_i,
  input  logic [DATA_W-1:0] add2_i,
  output logic [DATA_W-1:0] add1_o,
  output logic [DATA_W-1:0] add2_o,
  output logic [KEY_W-1:0]  keyinput_o,
  input  logic [DATA_W:0]   result_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W:0]   result_o
);

  localparam int CNT_W = $clog2(KEY_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);

  typedef enum logic [2:0] {
    NO_KEY   = 3'd0,
    LOAD_KEY = 3'd1,
    READY    = 3'd2,
    ISSUE    = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [KEY_W-1:0]   shift_r, shift_s, shifted_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [KEY_W-1:0]   key_r, key_s;
  logic               loaded_r, loaded_s;
  logic [DATA_W-1:0]  add1_r, add1_s, add2_r, add2_s;
  logic [DATA_W:0]    result_r, result_s;
  logic               out_valid_r, out_valid_s;
  logic               in_ready_s;

  // Next-state and next-value logic for every register.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    count_s     = count_r;
    key_s       = key_r;
    loaded_s    = loaded_r;
    add1_s      = add1_r;
    add2_s      = add2_r;
    result_s    = result_r;
    out_valid_s = out_valid_r;
    shifted_s   = {key_bit_i, shift_r[KEY_W-1:1]};
    in_ready_s  = (state_r == READY) & ~key_start_i;

    case (state_r)
      NO_KEY: begin
        if (key_start_i) begin
          state_s = LOAD_KEY;
          shift_s = {KEY_W{1'b0}};
          count_s = {CNT_W{1'b0}};
        end else begin
          state_s = NO_KEY;
        end
      end
      LOAD_KEY: begin
        // A restart wins over a bit arriving in the same cycle.
        if (key_start_i) begin
          shift_s = {KEY_W{1'b0}};
          count_s = {CNT_W{1'b0}};
        end else if (key_bit_valid_i) begin
          shift_s = shifted_s;
          if (count_r == LAST_BIT) begin
            state_s  = READY;
            key_s    = shifted_s;
            loaded_s = 1'b1;
            count_s  = {CNT_W{1'b0}};
          end else begin
            count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = LOAD_KEY;
        end
      end
      READY: begin
        if (key_start_i) begin
          state_s  = LOAD_KEY;
          shift_s  = {KEY_W{1'b0}};
          count_s  = {CNT_W{1'b0}};
          key_s    = {KEY_W{1'b0}};
          loaded_s = 1'b0;
        end else if (in_valid_i) begin
          state_s = ISSUE;
          add1_s  = add1_i;
          add2_s  = add2_i;
        end else begin
          state_s = READY;
        end
      end
      ISSUE: begin
        // Adder inputs have been stable for a full cycle; sample its output.
        state_s     = HOLD;
        result_s    = result_i;
        out_valid_s = 1'b1;
      end
      HOLD: begin
        if (out_ready_i) begin
          state_s     = READY;
          out_valid_s = 1'b0;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s     = NO_KEY;
        loaded_s    = 1'b0;
        key_s       = {KEY_W{1'b0}};
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= NO_KEY;
      shift_r     <= {KEY_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      key_r       <= {KEY_W{1'b0}};
      loaded_r    <= 1'b0;
      add1_r      <= {DATA_W{1'b0}};
      add2_r      <= {DATA_W{1'b0}};
      result_r    <= {(DATA_W+1){1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      count_r     <= count_s;
      key_r       <= key_s;
      loaded_r    <= loaded_s;
      add1_r      <= add1_s;
      add2_r      <= add2_s;
      result_r    <= result_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign key_loaded_o = loaded_r;
  assign keyinput_o   = key_r;
  assign in_ready_o   = in_ready_s;
  assign add1_o       = add1_r;
  assign add2_o       = add2_r;
  assign result_o     = result_r;
  assign out_valid_o  = out_valid_r;

endmodule

// File: tb/tb_locked_adder_key_loader.sv
// Directed plus randomized bench for locked_adder_key_loader; the adder stub sums the
// registered operands, and expectations come from bit queues and plain arithmetic.
module tb_locked_adder_key_loader;
  localparam int DATA_W = 16;
  localparam int KEY_W  = 32;

  logic              clk = 1'b0;
  logic              rst_i, key_start_i, key_bit_valid_i, key_bit_i;
  logic              key_loaded_o, in_valid_i, in_ready_o;
  logic [DATA_W-1:0] add1_i, add2_i, add1_o, add2_o;
  logic [KEY_W-1:0]  keyinput_o;
  logic [DATA_W:0]   result_i, result_o, stub_junk;
  logic              out_valid_o, out_ready_i, stub_override;

  int vectors = 0;
  int miscompares = 0;
  logic             exp_loaded;
  logic [KEY_W-1:0] exp_key;

  locked_adder_key_loader #(.DATA_W(DATA_W), .KEY_W(KEY_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .key_start_i(key_start_i),
    .key_bit_valid_i(key_bit_valid_i), .key_bit_i(key_bit_i),
    .key_loaded_o(key_loaded_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .add1_i(add1_i), .add2_i(add2_i), .add1_o(add1_o), .add2_o(add2_o),
    .keyinput_o(keyinput_o), .result_i(result_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .result_o(result_o)
  );

  // Adder stub; the override lets the bench wiggle result_i while a result is held.
  assign result_i = stub_override ? stub_junk : ({1'b0, add1_o} + {1'b0, add2_o});

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KEY_W-1:0] assemble(input bit q[$]);
    logic [KEY_W-1:0] v = {KEY_W{1'b0}};
    foreach (q[j]) v = v | (KEY_W'(q[j]) << j);
    return v;
  endfunction

  task automatic chk_key(input string tag);
    chk({tag, "_loaded"}, 64'(key_loaded_o), 64'(exp_loaded));
    chk({tag, "_key"}, 64'(keyinput_o), 64'(exp_key));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_loaded"}, 64'(key_loaded_o), 64'd0);
    chk({tag, "_key"}, 64'(keyinput_o), 64'd0);
    chk({tag, "_add1"}, 64'(add1_o), 64'd0);
    chk({tag, "_add2"}, 64'(add2_o), 64'd0);
    chk({tag, "_result"}, 64'(result_o), 64'd0);
    chk({tag, "_ovalid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_iready"}, 64'(in_ready_o), 64'd0);
  endtask

  task automatic start_pulse();
    key_start_i = 1'b1;
    #1 chk("iready_during_start", 64'(in_ready_o), 64'd0);
    tick();
    key_start_i = 1'b0;
    exp_loaded = 1'b0;
    exp_key = {KEY_W{1'b0}};
    chk_key("start");
  endtask

  task automatic send_bits(input logic [KEY_W-1:0] k, input int nbits, input bit gaps);
    bit q[$];
    for (int i = 0; i < nbits; i++) begin
      int g;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        key_bit_i = 1'($urandom);
        tick();
        chk_key("gap");
      end
      key_bit_valid_i = 1'b1;
      key_bit_i = k[i];
      q.push_back(k[i]);
      tick();
      key_bit_valid_i = 1'b0;
      if (q.size() == KEY_W) begin
        exp_loaded = 1'b1;
        exp_key = assemble(q);
      end
      chk_key("bit");
    end
  endtask

  task automatic txn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                     input int hold_cycles, input bit start_in_hold);
    logic [DATA_W:0] exp_sum;
    exp_sum = {1'b0, a} + {1'b0, b};
    in_valid_i = 1'b1;
    add1_i = a;
    add2_i = b;
    #1 chk("iready_idle", 64'(in_ready_o), 64'd1);
    tick();
    in_valid_i = 1'b0;
    add1_i = 16'($urandom);
    add2_i = 16'($urandom);
    chk("add1_o", 64'(add1_o), 64'(a));
    chk("add2_o", 64'(add2_o), 64'(b));
    chk("ovalid_issue", 64'(out_valid_o), 64'd0);
    tick();
    chk("result", 64'(result_o), 64'(exp_sum));
    chk("ovalid", 64'(out_valid_o), 64'd1);
    stub_override = 1'b1;
    for (int c = 0; c < hold_cycles; c++) begin
      in_valid_i = 1'($urandom);
      add1_i = 16'($urandom);
      stub_junk = 17'($urandom);
      key_start_i = start_in_hold && (c == 0);
      #1 chk("iready_hold", 64'(in_ready_o), 64'd0);
      tick();
      key_start_i = 1'b0;
      chk("result_hold", 64'(result_o), 64'(exp_sum));
      chk("ovalid_hold", 64'(out_valid_o), 64'd1);
      chk("add1_hold", 64'(add1_o), 64'(a));
      chk_key("hold");
    end
    out_ready_i = 1'b1;
    in_valid_i = 1'b1;
    add1_i = ~a;
    #1 chk("iready_consume", 64'(in_ready_o), 64'd0);
    tick();
    out_ready_i = 1'b0;
    in_valid_i = 1'b0;
    stub_override = 1'b0;
    chk("ovalid_drop", 64'(out_valid_o), 64'd0);
    chk("add1_not_taken", 64'(add1_o), 64'(a));
    #1 chk("iready_back", 64'(in_ready_o), 64'd1);
  endtask

  initial begin
    rst_i = 1'b1;
    key_start_i = 1'b0;
    key_bit_valid_i = 1'b0;
    key_bit_i = 1'b0;
    in_valid_i = 1'b0;
    add1_i = '0;
    add2_i = '0;
    out_ready_i = 1'b0;
    stub_override = 1'b0;
    stub_junk = '0;
    exp_loaded = 1'b0;
    exp_key = '0;
    repeat (2) tick();
    chk_zero("reset");
    rst_i = 1'b0;
    tick();

    // Idle with no key: bits and operands are ignored.
    for (int i = 0; i < 4; i++) begin
      key_bit_valid_i = 1'b1;
      key_bit_i = 1'b1;
      in_valid_i = 1'b1;
      #1 chk("iready_nokey", 64'(in_ready_o), 64'd0);
      tick();
      chk_key("nokey");
    end
    key_bit_valid_i = 1'b0;
    in_valid_i = 1'b0;

    start_pulse();
    send_bits(32'hA5A500FF, 32, 1'b0);
    chk("key_a5a500ff", 64'(keyinput_o), 64'hA5A500FF);

    txn(16'hFFFF, 16'h0001, 5, 1'b0);
    chk("carry_out", 64'(result_o), 64'h10000);
    txn(16'h1234, 16'h4321, 2, 1'b1);

    // Restart mid-load with a bit in the same cycle.
    start_pulse();
    send_bits($urandom, 20, 1'b1);
    key_start_i = 1'b1;
    key_bit_valid_i = 1'b1;
    key_bit_i = 1'b1;
    tick();
    key_start_i = 1'b0;
    key_bit_valid_i = 1'b0;
    chk_key("restart");
    send_bits(32'h12345678, 32, 1'b0);
    chk("key_12345678", 64'(keyinput_o), 64'h12345678);

    for (int r = 0; r < 4; r++) begin
      start_pulse();
      send_bits($urandom, 32, 1'b1);
      for (int t = 0; t < 3; t++)
        txn(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while in ISSUE.
    in_valid_i = 1'b1;
    add1_i = 16'h00AA;
    add2_i = 16'h0055;
    tick();
    in_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1 chk_zero("rst_issue");
    exp_loaded = 1'b0;
    exp_key = '0;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      key_bit_valid_i = 1'b1;
      key_bit_i = 1'($urandom);
      #1 chk("iready_after_rst", 64'(in_ready_o), 64'd0);
      tick();
      chk("ovalid_after_rst", 64'(out_valid_o), 64'd0);
      chk_key("after_rst");
    end
    in_valid_i = 1'b0;
    key_bit_valid_i = 1'b0;

    // Asynchronous reset at key bit 10.
    start_pulse();
    send_bits($urandom, 10, 1'b0);
    #2 rst_i = 1'b1;
    #1 chk_zero("rst_bit10");
    tick();
    rst_i = 1'b0;
    tick();
    chk_zero("post_rst_bit10");
    start_pulse();
    send_bits($urandom, 32, 1'b1);
    txn(16'($urandom), 16'($urandom), 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
